// File: rtl/wb_pkg.sv
// Shared types and offset math for the cache line fill / writeback adapters.
package wb_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, GAP, DONE} wb_state_t;

  localparam logic [1:0]  MEM_SIZE_WORD  = 2'd2;
  localparam int unsigned BYTES_PER_WORD = 4;

  // Clears the in-line offset bits; callers truncate to their own address width.
  function automatic logic [63:0] line_base(input logic [63:0] addr,
                                            input int unsigned offset_bits);
    logic [63:0] keep;
    keep = ~64'd0 << offset_bits;
    return addr & keep;
  endfunction

endpackage

// File: rtl/line_writeback_adapter.sv
// Writes one cache line back to main memory, one word per memory access.
// Define WB_DIRTY_MASK_EN to add dirty_mask_i and skip clean words.
module line_writeback_adapter
  import wb_pkg::*;
#(
  parameter int WORD_SIZE      = 32,
  parameter int WORDS_PER_LINE = 8,
  parameter int ADDR_SIZE      = 32
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic [ADDR_SIZE-1:0]                line_addr_i,
  input  logic [WORDS_PER_LINE*WORD_SIZE-1:0] line_data_i,
`ifdef WB_DIRTY_MASK_EN
  input  logic [WORDS_PER_LINE-1:0]           dirty_mask_i,
`endif
  output logic                                busy,
  output logic                                done,
  output logic                                mm_we,
  output logic [ADDR_SIZE-1:0]                mm_addr,
  output logic [WORD_SIZE-1:0]                mm_din,
  output logic [1:0]                          mm_size,
  output logic                                mm_rst,
  input  logic                                mm_valid
);

  localparam int IDX_W       = $clog2(WORDS_PER_LINE);
  localparam int WORD_BYTES  = WORD_SIZE / 8;
  localparam int WORD_SHIFT  = $clog2(WORD_BYTES);
  localparam int OFFSET_BITS = $clog2(WORDS_PER_LINE * WORD_BYTES);

  wb_state_t                          state_q, state_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [ADDR_SIZE-1:0]               base_q, base_d;
  logic [WORDS_PER_LINE*WORD_SIZE-1:0] line_q, line_d;
  logic [WORDS_PER_LINE-1:0]          mask_q, mask_d;
  logic                               busy_q, busy_d, done_q, done_d;
  logic                               mm_we_q, mm_we_d, mm_rst_q, mm_rst_d;
  logic [ADDR_SIZE-1:0]               mm_addr_q, mm_addr_d;
  logic [WORD_SIZE-1:0]               mm_din_q, mm_din_d;
  logic [WORDS_PER_LINE-1:0]          mask_in;
  logic [IDX_W:0]                     hit;

`ifdef WB_DIRTY_MASK_EN
  assign mask_in = dirty_mask_i;
`else
  assign mask_in = '1;
`endif

  logic [WORD_SIZE-1:0] in_words  [WORDS_PER_LINE];
  logic [WORD_SIZE-1:0] buf_words [WORDS_PER_LINE];

  genvar gi;
  generate
    for (gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_words
      assign in_words[gi]  = line_data_i[gi*WORD_SIZE +: WORD_SIZE];
      assign buf_words[gi] = line_q[gi*WORD_SIZE +: WORD_SIZE];
    end
  endgenerate

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [IDX_W:0] first_dirty(input logic [WORDS_PER_LINE-1:0] m,
                                                 input logic [IDX_W:0] from);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = WORDS_PER_LINE - 1; i >= 0; i--) begin
      if (m[i] && (i >= int'(from))) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    base_d    = base_q;
    line_d    = line_q;
    mask_d    = mask_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    mm_we_d   = mm_we_q;
    mm_rst_d  = 1'b0;
    mm_addr_d = mm_addr_q;
    mm_din_d  = mm_din_q;
    hit       = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d = ADDR_SIZE'(line_base(64'(line_addr_i), OFFSET_BITS));
          line_d = line_data_i;
          mask_d = mask_in;
          hit    = first_dirty(mask_in, '0);
          if (hit[IDX_W]) begin
            state_d   = WRITE;
            idx_d     = hit[IDX_W-1:0];
            busy_d    = 1'b1;
            mm_we_d   = 1'b1;
            mm_addr_d = base_d + (ADDR_SIZE'(idx_d) << WORD_SHIFT);
            mm_din_d  = in_words[idx_d];
          end else begin
            state_d = DONE;
            idx_d   = '0;
            done_d  = 1'b1;
          end
        end
      end
      WRITE: begin
        if (mm_valid) begin
          mm_we_d = 1'b0;
          hit     = first_dirty(mask_q, {1'b0, idx_q} + (IDX_W+1)'(1));
          if (hit[IDX_W]) begin
            state_d   = GAP;
            idx_d     = hit[IDX_W-1:0];
            mm_rst_d  = 1'b1;
            mm_addr_d = base_q + (ADDR_SIZE'(idx_d) << WORD_SHIFT);
            mm_din_d  = buf_words[idx_d];
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      GAP: begin
        state_d = WRITE;
        mm_we_d = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      base_q    <= '0;
      line_q    <= '0;
      mask_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mm_we_q   <= 1'b0;
      mm_rst_q  <= 1'b0;
      mm_addr_q <= '0;
      mm_din_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      base_q    <= base_d;
      line_q    <= line_d;
      mask_q    <= mask_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mm_we_q   <= mm_we_d;
      mm_rst_q  <= mm_rst_d;
      mm_addr_q <= mm_addr_d;
      mm_din_q  <= mm_din_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign mm_we   = mm_we_q;
  assign mm_rst  = mm_rst_q;
  assign mm_addr = mm_addr_q;
  assign mm_din  = mm_din_q;
  assign mm_size = MEM_SIZE_WORD;

endmodule
